resource_branch_pipe: RTL and testbench

//  Pipelined successor of the single-shot resource branch: issues pipeline read/write requests to an external

---
 rtl/resource_branch_pipe_pkg.sv | 9 +
 rtl/resource_branch_pipe_rb_fifo.sv | 42 ++++
 rtl/resource_branch_pipe.sv | 145 ++++++++++++++
 tb/tb_resource_branch_pipe.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/resource_branch_pipe_pkg.sv
// rtl/resource_branch_pipe_pkg.sv - tag layout shared by the resource branch pipe and its queues
package resource_branch_pipe_pkg;
   localparam int DEST_W     = 4;
   localparam int COMMIT_W   = 9;
   localparam int TAG_COMMIT = 0;
   localparam int TAG_DEST   = TAG_COMMIT + COMMIT_W;
   localparam int TAG_WRITE  = TAG_DEST + DEST_W;
   localparam int TAG_W      = TAG_WRITE + 1;
endpackage

// File: rtl/resource_branch_pipe_rb_fifo.sv
// rtl/resource_branch_pipe_rb_fifo.sv - rb_fifo: synchronous FIFO, async active-low reset
// Caller guarantees no push when full and no pop when empty.
module rb_fifo #(
   parameter int W = 8,
   parameter int D = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         empty
);
   localparam int AW = $clog2(D);
   localparam int PW = AW + 1;

   logic [W-1:0]  mem_q [D];
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;

   always_comb begin
      wptr_d = wptr_q + PW'(push);
      rptr_d = rptr_q + PW'(pop);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = mem_q[rptr_q[AW-1:0]];
   assign empty = (wptr_q == rptr_q);
endmodule

// File: rtl/resource_branch_pipe.sv
// rtl/resource_branch_pipe.sv - pipelined resource request issue with in-order tagged returns
// RESOURCE_BRANCH_PIPE_BYPASS_EN: read data reaches out_valid in the same cycle when the result queue is empty.
module resource_branch_pipe
   import resource_branch_pipe_pkg::*;
#(
   parameter int data_width   = 16,
   parameter int handle_width = 8,
   parameter int DEPTH        = 4
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           enable,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           write,
   input  logic [handle_width-1:0]        handle_in,
   input  logic [data_width-1:0]          arg_a_in,
   input  logic [data_width-1:0]          arg_b_in,
   input  logic [DEST_W-1:0]              dest_in,
   input  logic [COMMIT_W-1:0]            commit_id_in,
   output logic                           req_valid,
   input  logic                           req_ready,
   output logic                           req_write,
   output logic [handle_width-1:0]        req_handle,
   output logic signed [data_width-1:0]   req_arg_a,
   output logic signed [data_width-1:0]   req_arg_b,
   input  logic                           rsp_valid,
   input  logic signed [data_width-1:0]   rsp_data,
   input  logic                           write_ack,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [2*data_width-1:0]        result_out,
   output logic [DEST_W-1:0]              dest_out,
   output logic [COMMIT_W-1:0]            commit_id_out,
   output logic [$clog2(DEPTH):0]         outstanding,
   output logic                           proto_err
);
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int RES_W = 2*data_width + TAG_WRITE;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic                    iss_valid_q, iss_valid_d, iss_write_q, iss_write_d;
   logic [handle_width-1:0] iss_handle_q, iss_handle_d;
   logic [data_width-1:0]   iss_arg_a_q, iss_arg_a_d, iss_arg_b_q, iss_arg_b_d;
   logic [DEST_W-1:0]       iss_dest_q, iss_dest_d;
   logic [COMMIT_W-1:0]     iss_commit_q, iss_commit_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    err_q, err_d;

   logic             iss_fire, head_write, rsp_ok, ack_ok, accept, in_rdy;
   logic             res_push, res_pop, out_vld, out_fire, tag_empty, res_empty;
   logic [TAG_W-1:0] tag_wdata, tag_rdata;
   logic [RES_W-1:0] res_wdata, res_rdata, out_head;

   always_comb begin
      iss_fire   = iss_valid_q & req_ready;
      tag_wdata  = {iss_write_q, iss_dest_q, iss_commit_q};
      head_write = tag_rdata[TAG_WRITE];
      rsp_ok     = rsp_valid & ~write_ack & ~tag_empty & ~head_write;
      ack_ok     = write_ack & ~rsp_valid & ~tag_empty & head_write;
      res_wdata  = {{data_width{rsp_data[data_width-1]}}, rsp_data, tag_rdata[TAG_WRITE-1:0]};
`ifdef RESOURCE_BRANCH_PIPE_BYPASS_EN
      out_vld    = ~res_empty | rsp_ok;
      out_head   = res_empty ? res_wdata : res_rdata;
      res_push   = rsp_ok & ~(res_empty & out_ready);
`else
      out_vld    = ~res_empty;
      out_head   = res_rdata;
      res_push   = rsp_ok;
`endif
      out_fire   = out_vld & out_ready;
      res_pop    = ~res_empty & out_ready;
      // Credits released this cycle count toward acceptance so a full pipe keeps 1 req/cycle.
      in_rdy     = enable & (~iss_valid_q | req_ready) & ((cnt_q < DEPTH_C) | ack_ok | out_fire);
      accept     = in_valid & in_rdy;
      cnt_d      = cnt_q + CW'(accept) - CW'(ack_ok) - CW'(out_fire);
      err_d      = err_q | ((rsp_valid | write_ack) & ~(rsp_ok | ack_ok));

      iss_valid_d  = iss_valid_q;
      iss_write_d  = iss_write_q;
      iss_handle_d = iss_handle_q;
      iss_arg_a_d  = iss_arg_a_q;
      iss_arg_b_d  = iss_arg_b_q;
      iss_dest_d   = iss_dest_q;
      iss_commit_d = iss_commit_q;
      if (accept) begin
         iss_valid_d  = 1'b1;
         iss_write_d  = write;
         iss_handle_d = handle_in;
         iss_arg_a_d  = arg_a_in;
         iss_arg_b_d  = arg_b_in;
         iss_dest_d   = dest_in;
         iss_commit_d = commit_id_in;
      end else if (iss_fire) begin
         iss_valid_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iss_valid_q  <= 1'b0;
         iss_write_q  <= 1'b0;
         iss_handle_q <= '0;
         iss_arg_a_q  <= '0;
         iss_arg_b_q  <= '0;
         iss_dest_q   <= '0;
         iss_commit_q <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         iss_valid_q  <= iss_valid_d;
         iss_write_q  <= iss_write_d;
         iss_handle_q <= iss_handle_d;
         iss_arg_a_q  <= iss_arg_a_d;
         iss_arg_b_q  <= iss_arg_b_d;
         iss_dest_q   <= iss_dest_d;
         iss_commit_q <= iss_commit_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   rb_fifo #(.W(TAG_W), .D(DEPTH)) u_tag_q (
      .clk(clk), .reset_n(reset_n), .push(iss_fire), .wdata(tag_wdata),
      .pop(rsp_ok | ack_ok), .rdata(tag_rdata), .empty(tag_empty)
   );

   rb_fifo #(.W(RES_W), .D(DEPTH)) u_res_q (
      .clk(clk), .reset_n(reset_n), .push(res_push), .wdata(res_wdata),
      .pop(res_pop), .rdata(res_rdata), .empty(res_empty)
   );

   assign in_ready      = in_rdy;
   assign req_valid     = iss_valid_q;
   assign req_write     = iss_write_q;
   assign req_handle    = iss_handle_q;
   assign req_arg_a     = iss_arg_a_q;
   assign req_arg_b     = iss_arg_b_q;
   assign out_valid     = out_vld;
   assign result_out    = out_vld ? out_head[RES_W-1 -: 2*data_width] : '0;
   assign dest_out      = out_vld ? out_head[TAG_WRITE-1:TAG_DEST] : '0;
   assign commit_id_out = out_vld ? out_head[TAG_DEST-1:TAG_COMMIT] : '0;
   assign outstanding   = cnt_q;
   assign proto_err     = err_q;
endmodule

// File: tb/tb_resource_branch_pipe.sv
// tb/tb_resource_branch_pipe.sv - self-checking bench for resource_branch_pipe (default, non-bypass build)
module tb_resource_branch_pipe;
   logic clk = 1'b0;
   logic reset_n, enable, in_valid, in_ready, write;
   logic [7:0]  handle_in;
   logic [15:0] arg_a_in, arg_b_in;
   logic [3:0]  dest_in;
   logic [8:0]  commit_id_in;
   logic req_valid, req_ready, req_write;
   logic [7:0]  req_handle;
   logic [15:0] req_arg_a, req_arg_b;
   logic rsp_valid, write_ack, out_valid, out_ready, proto_err;
   logic [15:0] rsp_data;
   logic [31:0] result_out;
   logic [3:0]  dest_out;
   logic [8:0]  commit_id_out;
   logic [2:0]  outstanding;

   resource_branch_pipe #(.data_width(16), .handle_width(8), .DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
      .write(write), .handle_in(handle_in), .arg_a_in(arg_a_in), .arg_b_in(arg_b_in),
      .dest_in(dest_in), .commit_id_in(commit_id_in), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_handle(req_handle), .req_arg_a(req_arg_a), .req_arg_b(req_arg_b),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .write_ack(write_ack), .out_valid(out_valid),
      .out_ready(out_ready), .result_out(result_out), .dest_out(dest_out),
      .commit_id_out(commit_id_out), .outstanding(outstanding), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic w; logic [7:0] h; logic [15:0] a; logic [15:0] b; logic [3:0] d; logic [8:0] c;
   } req_t;
   typedef struct packed { logic [31:0] r; logic [3:0] d; logic [8:0] c; } res_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   req_t pend[$];      // accepted, not yet answered
   req_t acc_log[$];   // everything accepted, in order
   req_t resq[$];      // resource side: issued, awaiting its answer
   req_t req_seen[$];  // everything the DUT issued
   res_t exp_all[$];
   res_t got_all[$];
   logic exp_err, last_acc, auto_rsp;

   function automatic int model_out();
      return pend.size() + exp_all.size() - got_all.size();
   endfunction

   task automatic model_resp();
      req_t t;
      if ((rsp_valid && write_ack) || pend.size() == 0 || pend[0].w != write_ack) exp_err = 1'b1;
      else begin
         t = pend.pop_front();
         if (!t.w) exp_all.push_back({32'($signed(rsp_data)), t.d, t.c});
      end
   endtask

   // Called at a negedge with inputs set; observes handshakes just before the next posedge.
   task automatic tick();
      req_t s;
      req_t q;
      res_t o;
      if (auto_rsp) begin
         rsp_valid = 1'b0;
         write_ack = 1'b0;
         if (resq.size() > 0 && $urandom_range(0, 2) != 0) begin
            q = resq.pop_front();
            if (q.w) write_ack = 1'b1;
            else begin
               rsp_valid = 1'b1;
               rsp_data  = 16'($urandom);
            end
         end
      end
      #1;
      last_acc = in_valid && in_ready;
      if (rsp_valid || write_ack) model_resp();
      if (last_acc) begin
         s = {write, handle_in, arg_a_in, arg_b_in, dest_in, commit_id_in};
         pend.push_back(s);
         acc_log.push_back(s);
      end
      if (req_valid && req_ready) begin
         q = {req_write, req_handle, req_arg_a, req_arg_b, 4'h0, 9'h0};
         resq.push_back(q);
         req_seen.push_back(q);
      end
      if (out_valid && out_ready) begin
         o = {result_out, dest_out, commit_id_out};
         got_all.push_back(o);
      end
      @(negedge clk);
      if (auto_rsp) begin
         rsp_valid = 1'b0;
         write_ack = 1'b0;
      end
   endtask

   task automatic clear_model();
      pend.delete(); acc_log.delete(); resq.delete(); req_seen.delete();
      exp_all.delete(); got_all.delete();
      exp_err = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0; write = 1'b0; handle_in = '0;
      arg_a_in = '0; arg_b_in = '0; dest_in = '0; commit_id_in = '0; req_ready = 1'b1;
      rsp_valid = 1'b0; rsp_data = '0; write_ack = 1'b0; out_ready = 1'b1; auto_rsp = 1'b0;
      clear_model();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic rand_req(input logic w);
      write = w; handle_in = 8'($urandom); arg_a_in = 16'($urandom); arg_b_in = 16'($urandom);
      dest_in = 4'($urandom); commit_id_in = 9'($urandom);
   endtask

   task automatic test_reset();
      do_reset();
      reset_n = 1'b0; in_valid = 1'b1;
      @(negedge clk); #1;
      n_checks++;
      if (req_valid !== 1'b0 || out_valid !== 1'b0 || outstanding !== 3'd0 || proto_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: req_valid=%b out_valid=%b outstanding=%0d proto_err=%b, want 0 0 0 0",
                  req_valid, out_valid, outstanding, proto_err);
      end
      n_checks++;
      if (result_out !== 32'h0 || req_handle !== 8'h0 || dest_out !== 4'h0 || commit_id_out !== 9'h0) begin
         n_fail++;
         $display("FAIL reset_data: result=%h handle=%h dest=%h commit=%h, want all 0",
                  result_out, req_handle, dest_out, commit_id_out);
      end
      reset_n = 1'b1; in_valid = 1'b0;
      @(negedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_single_read();
      do_reset();
      write = 1'b0; handle_in = 8'd3; arg_a_in = 16'h0010; arg_b_in = 16'h1234;
      dest_in = 4'd5; commit_id_in = 9'h1A3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (last_acc !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", last_acc); end
      repeat (3) tick();
      n_checks++;
      if (req_seen.size() != 1 || req_seen[0].h !== 8'd3 || req_seen[0].a !== 16'h0010 || req_seen[0].w !== 1'b0) begin
         n_fail++; $display("FAIL single_req: issued %0d requests, want 1 read handle 3 arg_a 0010", req_seen.size());
      end
      rsp_valid = 1'b1; rsp_data = 16'h8001; out_ready = 1'b0;
      tick();
      rsp_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || result_out !== 32'hFFFF8001 || dest_out !== 4'd5 || commit_id_out !== 9'h1A3) begin
         n_fail++;
         $display("FAIL single_result: valid=%b result=%h dest=%0d commit=%h, want 1 ffff8001 5 1a3",
                  out_valid, result_out, dest_out, commit_id_out);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (got_all.size() != 1 || out_valid !== 1'b0 || outstanding !== 3'd0) begin
         n_fail++;
         $display("FAIL single_drain: pops=%0d out_valid=%b outstanding=%0d, want 1 0 0",
                  got_all.size(), out_valid, outstanding);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_req(1'b0); in_valid = 1'b1;
         tick();
         n_checks++;
         if (last_acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept%0d: got %b want 1", i, last_acc); end
      end
      rand_req(1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin rsp_valid = 1'b1; rsp_data = 16'($urandom); end
         tick();
         rsp_valid = 1'b0;
         n_checks++;
         if (last_acc !== 1'b0) begin n_fail++; $display("FAIL b2b_credit_block%0d: accepted=%b want 0", i, last_acc); end
      end
      n_checks++;
      if (outstanding !== 3'd4) begin n_fail++; $display("FAIL b2b_full: outstanding=%0d want 4", outstanding); end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      n_checks++;
      if (last_acc !== 1'b1) begin n_fail++; $display("FAIL b2b_pop_accept: accepted=%b want 1", last_acc); end
      for (int i = 0; i < 4; i++) begin
         if (i == 2) begin rsp_valid = 1'b1; rsp_data = 16'($urandom); end
         tick();
         rsp_valid = 1'b0;
      end
      n_checks++;
      if (got_all.size() != 5 || exp_all.size() != 5) begin
         n_fail++; $display("FAIL b2b_count: got %0d results, want 5 (model %0d)", got_all.size(), exp_all.size());
      end
      for (int i = 0; i < exp_all.size() && i < got_all.size(); i++) begin
         n_checks++;
         if (got_all[i] !== exp_all[i]) begin
            n_fail++; $display("FAIL b2b_order%0d: got %h want %h", i, got_all[i], exp_all[i]);
         end
      end
      n_checks++;
      if (outstanding !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: outstanding=%0d want 0", outstanding); end
   endtask

   task automatic test_mixed();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         rand_req(i[0] == 1'b0); in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (i[0] == 1'b0) write_ack = 1'b1;
         else begin rsp_valid = 1'b1; rsp_data = 16'($urandom); end
         tick();
         write_ack = 1'b0; rsp_valid = 1'b0;
         if (i == 0) begin
            n_checks++;
            if (outstanding !== 3'd3) begin n_fail++; $display("FAIL mixed_ack_credit: outstanding=%0d want 3", outstanding); end
         end
      end
      tick();
      n_checks++;
      if (got_all.size() != 2 || exp_all.size() != 2) begin
         n_fail++; $display("FAIL mixed_count: got %0d results, want 2", got_all.size());
      end
      for (int i = 0; i < exp_all.size() && i < got_all.size(); i++) begin
         n_checks++;
         if (got_all[i] !== exp_all[i]) begin n_fail++; $display("FAIL mixed_result%0d: got %h want %h", i, got_all[i], exp_all[i]); end
      end
      n_checks++;
      if (outstanding !== 3'd0 || proto_err !== 1'b0) begin
         n_fail++; $display("FAIL mixed_end: outstanding=%0d proto_err=%b want 0 0", outstanding, proto_err);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin rand_req(1'b0); in_valid = 1'b1; tick(); end
      in_valid = 1'b0;
      tick();
      for (int i = 0; i < 4; i++) begin
         rsp_valid = 1'b1; rsp_data = 16'($urandom);
         tick();
         rsp_valid = 1'b0;
      end
      repeat (2) tick();
      #1;
      n_checks++;
      if (in_ready !== 1'b0 || outstanding !== 3'd4 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold: in_ready=%b outstanding=%0d out_valid=%b want 0 4 1", in_ready, outstanding, out_valid);
      end
      n_checks++;
      if (exp_all.size() == 0 || result_out !== exp_all[0].r) begin
         n_fail++; $display("FAIL bp_head: result=%h want first read", result_out);
      end
      out_ready = 1'b1;
      repeat (4) tick();
      n_checks++;
      if (got_all.size() != 4 || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL bp_release: pops=%0d outstanding=%0d want 4 0", got_all.size(), outstanding);
      end
      for (int i = 0; i < exp_all.size() && i < got_all.size(); i++) begin
         n_checks++;
         if (got_all[i] !== exp_all[i]) begin n_fail++; $display("FAIL bp_order%0d: got %h want %h", i, got_all[i], exp_all[i]); end
      end
   endtask

   task automatic test_proto_err();
      do_reset();
      rsp_valid = 1'b1; rsp_data = 16'h1111;
      tick();
      rsp_valid = 1'b0;
      n_checks++;
      if (proto_err !== exp_err || proto_err !== 1'b1 || outstanding !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL perr_empty: proto_err=%b outstanding=%0d out_valid=%b want 1 0 0", proto_err, outstanding, out_valid);
      end
      rand_req(1'b0); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      write_ack = 1'b1;
      tick();
      write_ack = 1'b0;
      n_checks++;
      if (outstanding !== 3'd1 || out_valid !== 1'b0 || proto_err !== 1'b1) begin
         n_fail++; $display("FAIL perr_type: outstanding=%0d out_valid=%b proto_err=%b want 1 0 1", outstanding, out_valid, proto_err);
      end
      rsp_valid = 1'b1; write_ack = 1'b1; rsp_data = 16'h2222;
      tick();
      rsp_valid = 1'b0; write_ack = 1'b0;
      n_checks++;
      if (outstanding !== 3'd1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL perr_both: outstanding=%0d out_valid=%b want 1 0", outstanding, out_valid);
      end
      rsp_valid = 1'b1; rsp_data = 16'h7ABC;
      tick();
      rsp_valid = 1'b0;
      tick();
      n_checks++;
      if (got_all.size() != 1 || exp_all.size() != 1 || got_all[0] !== exp_all[0] || proto_err !== 1'b1) begin
         n_fail++; $display("FAIL perr_recover: pops=%0d proto_err=%b want 1 matching result, sticky 1", got_all.size(), proto_err);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 3; i++) begin rand_req(1'b0); in_valid = 1'b1; tick(); end
      in_valid = 1'b0;
      repeat (2) tick();
      n_checks++;
      if (outstanding !== 3'd3) begin n_fail++; $display("FAIL mrst_pre: outstanding=%0d want 3", outstanding); end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (outstanding !== 3'd0 || req_valid !== 1'b0 || out_valid !== 1'b0 || proto_err !== 1'b0) begin
         n_fail++; $display("FAIL mrst_async: outstanding=%0d req_valid=%b out_valid=%b proto_err=%b want 0", outstanding, req_valid, out_valid, proto_err);
      end
      clear_model();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      rand_req(1'b0); in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      rsp_valid = 1'b1; rsp_data = 16'($urandom);
      tick();
      rsp_valid = 1'b0;
      tick();
      n_checks++;
      if (got_all.size() != 1 || exp_all.size() != 1 || got_all[0] !== exp_all[0] || outstanding !== 3'd0) begin
         n_fail++; $display("FAIL mrst_after: pops=%0d outstanding=%0d want 1 matching result, 0", got_all.size(), outstanding);
      end
   endtask

   task automatic test_random();
      int sent = 0;
      int cyc  = 0;
      int bad  = 0;
      logic held;
      do_reset();
      auto_rsp = 1'b1;
      while (cyc < 2000 && (sent < 80 || model_out() != 0)) begin
         if (!in_valid && sent < 80 && $urandom_range(0, 1) == 1) begin
            rand_req(1'($urandom)); in_valid = 1'b1;
         end
         enable    = ($urandom_range(0, 7) != 0);
         req_ready = (sent >= 80) ? 1'b1 : 1'($urandom);
         out_ready = (sent >= 80) ? 1'b1 : 1'($urandom);
         held      = req_valid && !req_ready;
         tick();
         if (last_acc) begin in_valid = 1'b0; sent++; end
         n_checks++;
         if (int'(outstanding) != model_out() || (held && req_valid !== 1'b1)) begin
            n_fail++; bad++;
            if (bad < 5) $display("FAIL rand_credit@%0d: outstanding=%0d want %0d, req_valid=%b", cyc, outstanding, model_out(), req_valid);
         end
         cyc++;
      end
      auto_rsp = 1'b0;
      n_checks++;
      if (sent != 80 || model_out() != 0) begin
         n_fail++; $display("FAIL rand_timeout: sent %0d of 80, %0d still outstanding", sent, model_out());
      end
      n_checks++;
      if (req_seen.size() != acc_log.size() || got_all.size() != exp_all.size() || proto_err !== 1'b0) begin
         n_fail++; $display("FAIL rand_counts: issued %0d/%0d results %0d/%0d proto_err=%b",
                            req_seen.size(), acc_log.size(), got_all.size(), exp_all.size(), proto_err);
      end
      for (int i = 0; i < acc_log.size() && i < req_seen.size(); i++) begin
         n_checks++;
         if (req_seen[i].w !== acc_log[i].w || req_seen[i].h !== acc_log[i].h ||
             req_seen[i].a !== acc_log[i].a || req_seen[i].b !== acc_log[i].b) begin
            n_fail++; $display("FAIL rand_req%0d: got %h want %h", i, req_seen[i], acc_log[i]);
         end
      end
      for (int i = 0; i < exp_all.size() && i < got_all.size(); i++) begin
         n_checks++;
         if (got_all[i] !== exp_all[i]) begin n_fail++; $display("FAIL rand_res%0d: got %h want %h", i, got_all[i], exp_all[i]); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_read();
      test_back_to_back();
      test_mixed();
      test_backpressure();
      test_proto_err();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
